pe_compute_pipe: RTL and testbench

Pipelined, backpressured successor to the combinational PE compute unit. It accepts one operation per cycle over a valid/ready handshake and executes ADD/SUB/MUL/MAC/SQR in a 2-stage pipeline with optional fixed-point scaling. FN_DIV runs on a multi-cycle iterative signed divider. It sits between the PE operand-select logic and the PE result/writeback path, and returns results strictly in issue order.

---
 rtl/pe_compute_pipe_pkg.sv | 18 +
 rtl/pe_div_iter.sv | 65 ++++++
 rtl/pe_compute_pipe.sv | 84 ++++++++
 tb/tb_pe_compute_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pe_compute_pipe_pkg.sv
// pe_compute_pipe_pkg: function codes, divider state encoding and saturation constants shared by PE variants.
package pe_compute_pipe_pkg;
  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_MUL = 3'd2;
  localparam logic [2:0] FN_MAC = 3'd3;
  localparam logic [2:0] FN_DIV = 3'd4;
  localparam logic [2:0] FN_SQR = 3'd5;
  localparam logic [2:0] FN_SIG = 3'd6;
  localparam logic [2:0] FN_GAU = 3'd7;
  typedef enum logic [1:0] {DIV_IDLE, DIV_LOAD, DIV_ITER, DIV_FIX} div_state_t;
  function automatic logic [63:0] max_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] min_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/pe_div_iter.sv
// pe_div_iter: iterative signed restoring divider, one quotient bit per cycle, saturating on /0 and MIN/-1.
module pe_div_iter import pe_compute_pipe_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] dividend,
  input  logic signed [DATA_W-1:0] divisor,
  output logic                     busy,
  output logic [DATA_W-1:0]        quotient,
  output logic                     err
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MAX_POS = DATA_W'(max_pos(DATA_W));
  localparam logic [DATA_W-1:0] MIN_NEG = DATA_W'(min_neg(DATA_W));
  div_state_t st, st_n;
  logic signed [DATA_W-1:0] a_r, b_r;
  logic [DATA_W-1:0] q, b_mag, rem, rem_n, sat_val;
  logic [DATA_W:0] trial;
  logic [CW-1:0] cnt;
  logic neg, sat, ge;
  assign busy = st != DIV_IDLE;
  always_comb begin
    st_n = (st == DIV_IDLE && start) ? DIV_LOAD :
           (st == DIV_LOAD) ? DIV_ITER :
           (st == DIV_ITER && cnt == '0) ? DIV_FIX :
           (st == DIV_FIX) ? DIV_IDLE : st;
    trial = {rem, q[DATA_W-1]};
    ge = trial >= {1'b0, b_mag};
    rem_n = ge ? DATA_W'(trial - {1'b0, b_mag}) : trial[DATA_W-1:0];
  end
  // q starts as |dividend| and is shifted out while quotient bits shift in
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= DIV_IDLE;
      quotient <= '0;
      err <= 1'b0;
    end else begin
      st <= st_n;
      if (st == DIV_IDLE && start) begin
        a_r <= dividend;
        b_r <= divisor;
      end
      if (st == DIV_LOAD) begin
        q <= a_r[DATA_W-1] ? -a_r : a_r;
        b_mag <= b_r[DATA_W-1] ? -b_r : b_r;
        rem <= '0;
        neg <= a_r[DATA_W-1] ^ b_r[DATA_W-1];
        sat <= (b_r == '0) || (a_r == MIN_NEG && b_r == '1);
        sat_val <= (b_r == '0 && a_r[DATA_W-1]) ? MIN_NEG : MAX_POS;
        cnt <= CW'(DATA_W - 1);
      end
      if (st == DIV_ITER) begin
        rem <= rem_n;
        q <= {q[DATA_W-2:0], ge};
        cnt <= cnt - 1'b1;
      end
      if (st == DIV_FIX) begin
        quotient <= sat ? sat_val : neg ? -q : q;
        err <= sat;
      end
    end
  end
endmodule

// File: rtl/pe_compute_pipe.sv
// pe_compute_pipe: 2-stage in-order PE arithmetic pipe; define PE_DIV_EN to add the iterative FN_DIV divider.
module pe_compute_pipe import pe_compute_pipe_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int LOG_NUM_FN = 3,
  parameter int FRAC_W     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LOG_NUM_FN-1:0]    fn,
  input  logic signed [DATA_W-1:0] operand1,
  input  logic signed [DATA_W-1:0] operand2,
  input  logic signed [DATA_W-1:0] operand3,
  output logic signed [DATA_W-1:0] resultOut,
  output logic                     err,
  output logic                     done,
  input  logic                     out_ready
);
  localparam int PW = 2 * DATA_W;
  logic s1_full, s2_full, s2_div, s2_err, s1_adv, out_fire, s1_is_div;
  logic alu_err, div_busy, div_err;
  logic [LOG_NUM_FN-1:0] s1_fn;
  logic signed [DATA_W-1:0] s1_a, s1_b, s1_c, s2_res, alu_res, mul_res;
  logic [DATA_W-1:0] div_q;
  logic signed [PW-1:0] s1_prod;
  assign out_fire = done && out_ready;
  assign s1_adv = s1_full && (!s2_full || out_fire);
  assign in_ready = !reset && (!s1_full || s1_adv);
  assign done = s2_full && !(s2_div && div_busy);
  assign resultOut = s2_div ? div_q : s2_res;
  assign err = s2_div ? div_err : s2_err;
  always_comb begin
    mul_res = DATA_W'(s1_prod >>> FRAC_W);
    alu_err = s1_fn inside {FN_DIV, FN_SIG, FN_GAU};
    alu_res = (s1_fn == FN_ADD) ? s1_a + s1_b :
              (s1_fn == FN_SUB) ? s1_a - s1_b :
              (s1_fn == FN_MUL || s1_fn == FN_SQR) ? mul_res :
              (s1_fn == FN_MAC) ? mul_res + s1_c : '0;
  end
`ifdef PE_DIV_EN
  assign s1_is_div = s1_fn == FN_DIV;
  pe_div_iter #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (s1_adv && s1_is_div),
    .dividend (s1_a),
    .divisor  (s1_b),
    .busy     (div_busy),
    .quotient (div_q),
    .err      (div_err)
  );
`else
  assign s1_is_div = 1'b0;
  assign div_busy = 1'b0;
  assign div_q = '0;
  assign div_err = 1'b0;
`endif
  // a DIV in S2 stays occupied until the divider returns to idle
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_full <= 1'b0;
      s2_full <= 1'b0;
      s2_div <= 1'b0;
      s2_res <= '0;
      s2_err <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s1_full <= 1'b1;
        s1_fn <= fn;
        s1_a <= operand1;
        s1_b <= operand2;
        s1_c <= operand3;
        s1_prod <= PW'(operand1) * PW'(fn == FN_SQR ? operand1 : operand2);
      end else if (s1_adv) s1_full <= 1'b0;
      if (s1_adv) begin
        s2_full <= 1'b1;
        s2_div <= s1_is_div;
        s2_res <= alu_res;
        s2_err <= alu_err;
      end else if (out_fire) s2_full <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pe_compute_pipe.sv
// tb_pe_compute_pipe: scoreboard bench driving FRAC_W=0 and FRAC_W=8 instances in lockstep.
module tb_pe_compute_pipe;
`ifdef PE_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef struct {
    logic [31:0] r0;
    logic [31:0] r8;
    logic        e;
    int          lat;
    int          t0;
    bit          follow;
  } exp_t;
  logic clk, reset, in_valid, out_ready;
  logic in_ready, in_ready8, err0, err8, done0, done8;
  logic [2:0] fn;
  logic signed [31:0] operand1, operand2, operand3;
  logic [31:0] res0, res8;
  exp_t sb[$];
  int ntests = 0, nfail = 0, edges = 0, last_out = 0;
  bit lat_on = 0, follow_on = 0;

  pe_compute_pipe #(.DATA_W(32), .LOG_NUM_FN(3), .FRAC_W(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .fn(fn),
    .operand1(operand1), .operand2(operand2), .operand3(operand3),
    .resultOut(res0), .err(err0), .done(done0), .out_ready(out_ready));
  pe_compute_pipe #(.DATA_W(32), .LOG_NUM_FN(3), .FRAC_W(8)) u_f8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8), .fn(fn),
    .operand1(operand1), .operand2(operand2), .operand3(operand3),
    .resultOut(res8), .err(err8), .done(done8), .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [2:0] f, input logic signed [31:0] a, b, c, input int fw);
    logic signed [63:0] p;
    logic [31:0] m;
    p = 64'(a) * 64'(f == 3'd5 ? a : b);
    m = 32'(p >>> fw);
    case (f)
      3'd0: return {1'b0, 32'(a + b)};
      3'd1: return {1'b0, 32'(a - b)};
      3'd2, 3'd5: return {1'b0, m};
      3'd3: return {1'b0, 32'(m + c)};
      3'd4: begin
        if (!DIV_EN) return {1'b1, 32'd0};
        if (b == 0) return {1'b1, (a < 0) ? 32'h8000_0000 : 32'h7fff_ffff};
        if (a == 32'sh8000_0000 && b == -1) return {1'b1, 32'h7fff_ffff};
        return {1'b0, 32'(a / b)};
      end
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // outputs are checked and accepted inputs recorded half a cycle before the edge that transfers them
  always @(negedge clk) begin
    exp_t e;
    logic [32:0] m0, m8;
    if (reset) sb.delete();
    else begin
      if (done0 && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 32'(done0), 32'd0);
        else begin
          e = sb.pop_front();
          chk("res", res0, e.r0);
          chk("res_f8", res8, e.r8);
          chk("err", 32'(err0), 32'(e.e));
          chk("err_f8", 32'(err8), 32'(e.e));
          chk("done_f8", 32'(done8), 32'd1);
          if (e.lat != 0) chk("latency", 32'(edges - e.t0), 32'(e.lat));
          if (e.follow) chk("follow_gap", 32'(edges - last_out), 32'd1);
          last_out = edges;
        end
      end
      if (in_valid && in_ready) begin
        m0 = model(fn, operand1, operand2, operand3, 0);
        m8 = model(fn, operand1, operand2, operand3, 8);
        e.r0 = m0[31:0];
        e.r8 = m8[31:0];
        e.e = m0[32];
        e.lat = !lat_on ? 0 : (DIV_EN && fn == 3'd4) ? 36 : 2;
        e.t0 = edges;
        e.follow = follow_on;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [2:0] f, input logic [31:0] a, b, c);
    int n;
    fn = f; operand1 = a; operand2 = b; operand3 = c; in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fn = '0;
    operand1 = '0; operand2 = '0; operand3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_res", res0, 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_in_ready_f8", 32'(in_ready8), 32'd1);
    @(posedge clk); #1;
    lat_on = 1;
    send(3'd0, 5, 7, 0);
    drain();
    send(3'd3, 3, 4, 5);
    send(3'd1, 2, 9, 0);
    send(3'd2, -6, 7, 0);
    send(3'd2, 32'h200, 32'h300, 0);
    send(3'd5, -5, 0, 0);
    send(3'd2, 32'h1_0000, 32'h1_0000, 0);
    send(3'd0, 32'h7fff_ffff, 1, 0);
    send(3'd1, 32'h8000_0000, 1, 0);
    send(3'd6, 1, 2, 3);
    send(3'd7, 4, 5, 6);
    drain();
    send(3'd4, -17, 5, 0);
    drain();
    send(3'd4, 9, 0, 0);
    send(3'd4, -9, 0, 0);
    send(3'd4, 32'h8000_0000, -1, 0);
    send(3'd4, 8, 2, 0);
    drain();
    lat_on = 0;
    send(3'd4, 50, 7, 0);
    follow_on = 1;
    send(3'd0, 3, 4, 0);
    follow_on = 0;
    drain();
    // backpressure: third ADD must wait until the consumer drains
    out_ready = 1'b0; fn = 3'd0; operand3 = 0;
    operand1 = 10; operand2 = 1; in_valid = 1'b1;
    @(posedge clk); #1;
    operand1 = 20; operand2 = 2;
    @(posedge clk); #1;
    operand1 = 30; operand2 = 3;
    @(negedge clk); #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_accepted", 32'(sb.size()), 32'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_res", res0, 32'd11);
      chk("bp_hold_done", 32'(done0), 32'd1);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("bp_resume", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    send(3'd4, 100, 7, 0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(done0), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_sb", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    send(3'd0, 1, 1, 0);
    drain();
    repeat (45) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
